// File: rtl/rob_banked_pkg.sv
// Shared parameters and entry type for the banked reorder buffer.
// Per-slot exception tracking is added when ROB_EXCEPTION_EN is defined.
package rob_banked_pkg;
    localparam int ROB_SIZE             = 16;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int WB_WIDTH             = 3;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ARCH_AW              = 5;
    localparam int ROW_AW               = $clog2(ROB_SIZE);
    localparam int BANK_AW              = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

    typedef logic [ROW_AW:0]               ptr_t;
    typedef logic [ROW_AW-1:0]             row_t;
    typedef logic [BANK_AW-1:0]            bank_t;
    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_t;
    typedef logic [ARCH_AW-1:0]            arch_t;

    typedef struct packed {
        logic  valid;
        phys_t phys_rd;
        arch_t arch_rd;
        logic  ready;
`ifdef ROB_EXCEPTION_EN
        logic  exc;
`endif
    } rob_entry_t;
endpackage

// File: rtl/rob_banked_bank.sv
// rob_bank: one column of the reorder buffer (one slot per row). Exception bits
// are stored only when ROB_EXCEPTION_EN is defined.
module rob_bank
    import rob_banked_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_we,
    input  row_t                       disp_addr,
    input  phys_t                      disp_phys,
    input  arch_t                      disp_arch,
    input  logic [WB_WIDTH-1:0]        wb_en,
    input  logic [WB_WIDTH*ROW_AW-1:0] wb_addr,
`ifdef ROB_EXCEPTION_EN
    input  logic [WB_WIDTH-1:0]        wb_exc,
`endif
    input  logic                       clr_en,
    input  row_t                       rd_addr,
    output rob_entry_t                 rd_entry
);
    logic [ROB_SIZE-1:0] valid_q, valid_d, ready_q, ready_d;
    phys_t               phys_q [ROB_SIZE];
    arch_t               arch_q [ROB_SIZE];
`ifdef ROB_EXCEPTION_EN
    logic [ROB_SIZE-1:0] exc_q, exc_d;
`endif

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
        valid_d = valid_q;
        ready_d = ready_q;
`ifdef ROB_EXCEPTION_EN
        exc_d   = exc_q;
`endif
        // Completions to slots that are not allocated are dropped.
        for (int p = 0; p < WB_WIDTH; p++) begin
            if (wb_en[p] && valid_q[wb_addr[p*ROW_AW +: ROW_AW]]) begin
                ready_d[wb_addr[p*ROW_AW +: ROW_AW]] = 1'b1;
`ifdef ROB_EXCEPTION_EN
                exc_d[wb_addr[p*ROW_AW +: ROW_AW]] = exc_d[wb_addr[p*ROW_AW +: ROW_AW]] | wb_exc[p];
`endif
            end
        end
        if (disp_we) begin
            valid_d[disp_addr] = 1'b1;
            ready_d[disp_addr] = 1'b0;
`ifdef ROB_EXCEPTION_EN
            exc_d[disp_addr]   = 1'b0;
`endif
        end
        if (clr_en) begin
            valid_d[rd_addr] = 1'b0;
            ready_d[rd_addr] = 1'b0;
`ifdef ROB_EXCEPTION_EN
            exc_d[rd_addr]   = 1'b0;
`endif
        end
        if (flush) begin
            valid_d = '0;
            ready_d = '0;
`ifdef ROB_EXCEPTION_EN
            exc_d   = '0;
`endif
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ready_q <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
`ifdef ROB_EXCEPTION_EN
            exc_q   <= exc_d;
`endif
        end
    end

    // NOTE: payload storage is deliberately not reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (disp_we) begin
            phys_q[disp_addr] <= disp_phys;
            arch_q[disp_addr] <= disp_arch;
        end
    end

    always_comb begin
        rd_entry         = '0;
        rd_entry.valid   = valid_q[rd_addr];
        rd_entry.ready   = ready_q[rd_addr];
        rd_entry.phys_rd = phys_q[rd_addr];
        rd_entry.arch_rd = arch_q[rd_addr];
`ifdef ROB_EXCEPTION_EN
        rd_entry.exc     = exc_q[rd_addr];
`endif
    end
endmodule

// File: rtl/rob_banked.sv
// Banked reorder buffer: in-order row allocate/retire with wrap-bit pointers and flush.
// ROB_EXCEPTION_EN adds partial-row commit on exception followed by a full flush.
module rob_banked
    import rob_banked_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [DISPATCH_WIDTH-1:0]                dispatch_en,
    input  logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] dispatch_phys_rd,
    input  logic [DISPATCH_WIDTH*ARCH_AW-1:0]        dispatch_arch_rd,
    output logic [ROW_AW-1:0]                        dispatch_rob_addr,
    output logic                                     full,
    output logic                                     empty,
    output logic [ROW_AW:0]                          num_rows,
    input  logic [WB_WIDTH-1:0]                      writeback_en,
    input  logic [WB_WIDTH*ROW_AW-1:0]               writeback_rob_addr,
    input  logic [WB_WIDTH*BANK_AW-1:0]              writeback_bank_addr,
    input  logic [WB_WIDTH-1:0]                      writeback_exc,
    output logic [DISPATCH_WIDTH-1:0]                commit_en,
    output logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
    output logic [DISPATCH_WIDTH*ARCH_AW-1:0]        commit_arch_rd
`ifdef ROB_EXCEPTION_EN
    ,
    output logic                                     exception_valid,
    output logic [ROW_AW-1:0]                        exception_rob_addr,
    output logic [BANK_AW-1:0]                       exception_bank_addr
`endif
);
    localparam int PW = PHYS_REGS_ADDR_WIDTH;

    ptr_t alloc_q, alloc_d, commit_q, commit_d;
    logic [DISPATCH_WIDTH-1:0]         commit_en_q, commit_en_d;
    logic [DISPATCH_WIDTH*PW-1:0]      commit_phys_q, commit_phys_d;
    logic [DISPATCH_WIDTH*ARCH_AW-1:0] commit_arch_q, commit_arch_d;
    rob_entry_t                        head [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0]         head_valid, head_ready, commit_mask;
    logic commit_ready, dispatch_fire, exc_flush, bank_flush;
`ifdef ROB_EXCEPTION_EN
    logic [DISPATCH_WIDTH-1:0] head_exc;
    logic  exc_hit;
    bank_t exc_bank;
    logic  exc_valid_q, exc_valid_d;
    row_t  exc_row_q, exc_row_d;
    bank_t exc_bank_q, exc_bank_d;
`else
    logic  unused_wb_exc;
    assign unused_wb_exc = ^writeback_exc;
`endif

    assign empty             = (alloc_q == commit_q);
    assign full              = (alloc_q[ROW_AW-1:0] == commit_q[ROW_AW-1:0]) && (alloc_q[ROW_AW] != commit_q[ROW_AW]);
    assign num_rows          = alloc_q - commit_q;
    assign dispatch_rob_addr = alloc_q[ROW_AW-1:0];
    assign dispatch_fire     = (|dispatch_en) && !full && !flush;
    assign bank_flush        = flush || exc_flush;

    for (genvar w = 0; w < DISPATCH_WIDTH; w++) begin : g_bank
        logic [WB_WIDTH-1:0] bank_wb_en;
        for (genvar p = 0; p < WB_WIDTH; p++) begin : g_port
            assign bank_wb_en[p] = writeback_en[p] && (writeback_bank_addr[p*BANK_AW +: BANK_AW] == bank_t'(w));
        end
        rob_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .flush     (bank_flush),
            .disp_we   (dispatch_fire && dispatch_en[w]),
            .disp_addr (alloc_q[ROW_AW-1:0]),
            .disp_phys (dispatch_phys_rd[w*PW +: PW]),
            .disp_arch (dispatch_arch_rd[w*ARCH_AW +: ARCH_AW]),
            .wb_en     (bank_wb_en),
            .wb_addr   (writeback_rob_addr),
`ifdef ROB_EXCEPTION_EN
            .wb_exc    (writeback_exc),
`endif
            .clr_en    (commit_ready && !flush),
            .rd_addr   (commit_q[ROW_AW-1:0]),
            .rd_entry  (head[w])
        );
        assign head_valid[w] = head[w].valid;
        assign head_ready[w] = head[w].ready;
`ifdef ROB_EXCEPTION_EN
        assign head_exc[w]   = head[w].exc;
`endif
    end

    always_comb begin
        commit_ready = (|head_valid) && ((head_valid & ~head_ready) == '0);
        commit_mask  = head_valid;
        exc_flush    = 1'b0;
`ifdef ROB_EXCEPTION_EN
        exc_hit  = 1'b0;
        exc_bank = '0;
        // Descending scan so the lowest excepting bank wins.
        for (int w = DISPATCH_WIDTH - 1; w >= 0; w--) begin
            if (head_valid[w] && head_exc[w]) begin
                exc_hit  = 1'b1;
                exc_bank = bank_t'(w);
            end
        end
        if (exc_hit) begin
            for (int w = 0; w < DISPATCH_WIDTH; w++) begin
                if (w >= int'(exc_bank)) commit_mask[w] = 1'b0;
            end
        end
        exc_flush   = commit_ready && exc_hit && !flush;
        exc_valid_d = exc_flush;
        exc_row_d   = exc_flush ? commit_q[ROW_AW-1:0] : exc_row_q;
        exc_bank_d  = exc_flush ? exc_bank : exc_bank_q;
`endif
    end

    always_comb begin
        alloc_d       = alloc_q;
        commit_d      = commit_q;
        commit_en_d   = '0;
        commit_phys_d = commit_phys_q;
        commit_arch_d = commit_arch_q;
        if (!flush) begin
            if (dispatch_fire) alloc_d = alloc_q + ptr_t'(1);
            if (commit_ready) begin
                commit_en_d = commit_mask;
                commit_d    = commit_q + ptr_t'(1);
                for (int w = 0; w < DISPATCH_WIDTH; w++) begin
                    commit_phys_d[w*PW +: PW]           = head[w].phys_rd;
                    commit_arch_d[w*ARCH_AW +: ARCH_AW] = head[w].arch_rd;
                end
            end
        end
        if (bank_flush) begin
            alloc_d  = '0;
            commit_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q       <= '0;
            commit_q      <= '0;
            commit_en_q   <= '0;
            commit_phys_q <= '0;
            commit_arch_q <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_valid_q   <= 1'b0;
            exc_row_q     <= '0;
            exc_bank_q    <= '0;
`endif
        end else begin
            alloc_q       <= alloc_d;
            commit_q      <= commit_d;
            commit_en_q   <= commit_en_d;
            commit_phys_q <= commit_phys_d;
            commit_arch_q <= commit_arch_d;
`ifdef ROB_EXCEPTION_EN
            exc_valid_q   <= exc_valid_d;
            exc_row_q     <= exc_row_d;
            exc_bank_q    <= exc_bank_d;
`endif
        end
    end

    assign commit_en      = commit_en_q;
    assign commit_phys_rd = commit_phys_q;
    assign commit_arch_rd = commit_arch_q;
`ifdef ROB_EXCEPTION_EN
    assign exception_valid     = exc_valid_q;
    assign exception_rob_addr  = exc_row_q;
    assign exception_bank_addr = exc_bank_q;
`endif
endmodule

// File: tb/tb_rob_banked.sv
// Self-checking bench for rob_banked: scoreboard of expected commits fed at dispatch,
// drained by a commit monitor. Exception scenario compiled in with ROB_EXCEPTION_EN.
`timescale 1ns/1ps
module tb_rob_banked;
    import rob_banked_pkg::*;
    localparam int P  = PHYS_REGS_ADDR_WIDTH;
    localparam int DW = DISPATCH_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [DW-1:0]              dispatch_en = '0;
    logic [DW*P-1:0]            dispatch_phys_rd = '0;
    logic [DW*ARCH_AW-1:0]      dispatch_arch_rd = '0;
    logic [ROW_AW-1:0]          dispatch_rob_addr;
    logic                       full, empty;
    logic [ROW_AW:0]            num_rows;
    logic [WB_WIDTH-1:0]        writeback_en = '0;
    logic [WB_WIDTH*ROW_AW-1:0] writeback_rob_addr = '0;
    logic [WB_WIDTH*BANK_AW-1:0] writeback_bank_addr = '0;
    logic [WB_WIDTH-1:0]        writeback_exc = '0;
    logic [DW-1:0]              commit_en;
    logic [DW*P-1:0]            commit_phys_rd;
    logic [DW*ARCH_AW-1:0]      commit_arch_rd;
`ifdef ROB_EXCEPTION_EN
    logic                       exception_valid;
    logic [ROW_AW-1:0]          exception_rob_addr;
    logic [BANK_AW-1:0]         exception_bank_addr;
`endif

    rob_banked dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_phys_rd(dispatch_phys_rd), .dispatch_arch_rd(dispatch_arch_rd),
        .dispatch_rob_addr(dispatch_rob_addr), .full(full), .empty(empty), .num_rows(num_rows),
        .writeback_en(writeback_en), .writeback_rob_addr(writeback_rob_addr),
        .writeback_bank_addr(writeback_bank_addr), .writeback_exc(writeback_exc),
        .commit_en(commit_en), .commit_phys_rd(commit_phys_rd), .commit_arch_rd(commit_arch_rd)
`ifdef ROB_EXCEPTION_EN
        , .exception_valid(exception_valid), .exception_rob_addr(exception_rob_addr),
        .exception_bank_addr(exception_bank_addr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]         en;
        logic [DW*P-1:0]       phys;
        logic [DW*ARCH_AW-1:0] arch;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            n_vec  = 0;
    int            n_err  = 0;
    int            m_alloc = 0;
    int            m_rows  = 0;
    logic [DW-1:0] row_en [ROB_SIZE];

    // Commit monitor: every retire strobe must match the oldest outstanding row.
    always @(posedge clk) begin
        #1;
        if (commit_en !== '0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ghost_commit: commit_en=%b, expected no commit", commit_en);
            end else begin
                cur = exp_q.pop_front();
                m_rows--;
                if (commit_en !== cur.en) begin
                    n_err++;
                    $display("FAIL commit_en: got %b, expected %b", commit_en, cur.en);
                end
                for (int w = 0; w < DW; w++) begin
                    if (cur.en[w]) begin
                        n_vec++;
                        if (commit_phys_rd[w*P +: P] !== cur.phys[w*P +: P] ||
                            commit_arch_rd[w*ARCH_AW +: ARCH_AW] !== cur.arch[w*ARCH_AW +: ARCH_AW]) begin
                            n_err++;
                            $display("FAIL commit_data bank%0d: got phys=%0d arch=%0d, expected phys=%0d arch=%0d", w,
                                     commit_phys_rd[w*P +: P], commit_arch_rd[w*ARCH_AW +: ARCH_AW],
                                     cur.phys[w*P +: P], cur.arch[w*ARCH_AW +: ARCH_AW]);
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus: optional dispatch plus writeback of every bank in wb_mask of row wb_row.
    task automatic step(input logic [DW-1:0] den, input logic [DW*P-1:0] phys,
                        input logic [DW*ARCH_AW-1:0] arch, input int wb_row,
                        input logic [DW-1:0] wb_mask, input logic [DW-1:0] exc_mask);
        logic accept;
        exp_t e;
        accept = (den != '0) && (m_rows < ROB_SIZE) && !flush;
        if (den != '0) begin
            n_vec++;
            if (dispatch_rob_addr !== row_t'(m_alloc)) begin
                n_err++;
                $display("FAIL dispatch_rob_addr: got %0d, expected %0d", dispatch_rob_addr, m_alloc);
            end
        end
        dispatch_en         = den;
        dispatch_phys_rd    = phys;
        dispatch_arch_rd    = arch;
        writeback_en        = '0;
        writeback_exc       = '0;
        writeback_rob_addr  = '0;
        writeback_bank_addr = '0;
        for (int w = 0; w < DW; w++) begin
            if (wb_mask[w]) begin
                writeback_en[w] = 1'b1;
                writeback_exc[w] = exc_mask[w];
                writeback_rob_addr[w*ROW_AW +: ROW_AW] = row_t'(wb_row);
                writeback_bank_addr[w*BANK_AW +: BANK_AW] = bank_t'(w);
            end
        end
        // Last port duplicates port 0's target: same-slot completions must OR together.
        if (wb_mask[0]) begin
            writeback_en[WB_WIDTH-1] = 1'b1;
            writeback_rob_addr[(WB_WIDTH-1)*ROW_AW +: ROW_AW] = row_t'(wb_row);
            writeback_bank_addr[(WB_WIDTH-1)*BANK_AW +: BANK_AW] = '0;
        end
        if (accept) begin
            e.en = den; e.phys = phys; e.arch = arch;
            exp_q.push_back(e);
            row_en[m_alloc] = den;
            m_alloc = (m_alloc + 1) % ROB_SIZE;
            m_rows++;
        end
        @(posedge clk);
        #2;
        dispatch_en   = '0;
        writeback_en  = '0;
        writeback_exc = '0;
    endtask

    task automatic rand_step(input logic [DW-1:0] den, input int wb_row, input logic [DW-1:0] wb_mask);
        step(den, (DW*P)'($urandom), (DW*ARCH_AW)'($urandom), wb_row, wb_mask, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 0, '0, '0);
    endtask

    task automatic complete_all();
        int cnt = m_rows;
        int row = (m_alloc - m_rows + ROB_SIZE) % ROB_SIZE;
        for (int i = 0; i < cnt; i++) begin
            step('0, '0, '0, row, row_en[row], '0);
            row = (row + 1) % ROB_SIZE;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (m_rows != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_vec++;
        if (m_rows != 0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL drain: rows outstanding=%0d empty=%b after %0d cycles, expected 0 and 1", m_rows, empty, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        n_vec += 6;
        if (empty !== 1'b1)             begin n_err++; $display("FAIL reset_empty: got %b, expected 1", empty); end
        if (full !== 1'b0)              begin n_err++; $display("FAIL reset_full: got %b, expected 0", full); end
        if (num_rows !== '0)            begin n_err++; $display("FAIL reset_num_rows: got %0d, expected 0", num_rows); end
        if (commit_en !== '0)           begin n_err++; $display("FAIL reset_commit_en: got %b, expected 0", commit_en); end
        if (commit_phys_rd !== '0 || commit_arch_rd !== '0) begin
            n_err++; $display("FAIL reset_commit_rd: got phys=%h arch=%h, expected 0", commit_phys_rd, commit_arch_rd);
        end
        if (dispatch_rob_addr !== '0)   begin n_err++; $display("FAIL reset_alloc: got %0d, expected 0", dispatch_rob_addr); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < ROB_SIZE; i++) begin
            rand_step(2'b11, 0, '0);
            n_vec++;
            if (num_rows !== (ROW_AW+1)'(i + 1)) begin
                n_err++; $display("FAIL fill_num_rows: got %0d, expected %0d", num_rows, i + 1);
            end
        end
        n_vec++;
        if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b, expected 1", full); end
        rand_step(2'b11, 0, '0);
        n_vec++;
        if (num_rows !== (ROW_AW+1)'(ROB_SIZE) || full !== 1'b1) begin
            n_err++; $display("FAIL fill_drop: got num_rows=%0d full=%b, expected %0d and 1", num_rows, full, ROB_SIZE);
        end
        complete_all();
        wait_drain(40);
    endtask

    task automatic test_single();
        int row = m_alloc;
        step(2'b01, {6'd0, 6'd7}, {5'd0, 5'd3}, 0, '0, '0);
        step('0, '0, '0, row, 2'b01, '0);
        n_vec++;
        if (commit_en !== '0) begin n_err++; $display("FAIL single_early: got commit_en=%b, expected 00", commit_en); end
        @(posedge clk);
        #2;
        n_vec += 2;
        if (commit_en !== 2'b01 || commit_phys_rd[P-1:0] !== 6'd7 || commit_arch_rd[ARCH_AW-1:0] !== 5'd3) begin
            n_err++;
            $display("FAIL single_commit: got en=%b phys=%0d arch=%0d, expected 01 7 3",
                     commit_en, commit_phys_rd[P-1:0], commit_arch_rd[ARCH_AW-1:0]);
        end
        if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b, expected 1", empty); end
    endtask

    task automatic test_order();
        int row_a = m_alloc;
        int row_b = (m_alloc + 1) % ROB_SIZE;
        rand_step(2'b11, 0, '0);
        rand_step(2'b11, 0, '0);
        step('0, '0, '0, row_b, 2'b11, '0);
        idle(3);
        n_vec++;
        if (num_rows !== (ROW_AW+1)'(2) || commit_en !== '0) begin
            n_err++; $display("FAIL order_hold: got num_rows=%0d commit_en=%b, expected 2 and 00", num_rows, commit_en);
        end
        step('0, '0, '0, row_a, 2'b11, '0);
        @(posedge clk);
        #2;
        n_vec++;
        if (commit_en !== 2'b11 || num_rows !== (ROW_AW+1)'(1)) begin
            n_err++; $display("FAIL order_first: got en=%b num_rows=%0d, expected 11 and 1", commit_en, num_rows);
        end
        @(posedge clk);
        #2;
        n_vec++;
        if (commit_en !== 2'b11 || num_rows !== '0) begin
            n_err++; $display("FAIL order_second: got en=%b num_rows=%0d, expected 11 and 0", commit_en, num_rows);
        end
    endtask

    task automatic test_full_wrap();
        int head;
        int prev;
        for (int i = 0; i < ROB_SIZE; i++) rand_step(2'(1 + ($urandom % 3)), 0, '0);
        head = (m_alloc - m_rows + ROB_SIZE) % ROB_SIZE;
        step('0, '0, '0, head, row_en[head], '0);
        rand_step(2'b11, 0, '0);
        n_vec++;
        if (num_rows !== (ROW_AW+1)'(ROB_SIZE - 1) || full !== 1'b0) begin
            n_err++; $display("FAIL wrap_drop_on_retire: got num_rows=%0d full=%b, expected %0d and 0", num_rows, full, ROB_SIZE - 1);
        end
        rand_step(2'b11, 0, '0);
        n_vec++;
        if (num_rows !== (ROW_AW+1)'(ROB_SIZE) || full !== 1'b1) begin
            n_err++; $display("FAIL wrap_refill: got num_rows=%0d full=%b, expected %0d and 1", num_rows, full, ROB_SIZE);
        end
        complete_all();
        wait_drain(40);
        prev = -1;
        for (int k = 0; k < 3 * ROB_SIZE; k++) begin
            int row = m_alloc;
            if (prev >= 0) rand_step(2'(1 + ($urandom % 3)), prev, row_en[prev]);
            else           rand_step(2'(1 + ($urandom % 3)), 0, '0);
            prev = row;
        end
        step('0, '0, '0, prev, row_en[prev], '0);
        wait_drain(20);
    endtask

    task automatic test_flush();
        int head;
        for (int i = 0; i < 5; i++) rand_step(2'b11, 0, '0);
        head = (m_alloc - m_rows + ROB_SIZE) % ROB_SIZE;
        flush = 1'b1;
        rand_step(2'b11, head, row_en[head]);
        flush = 1'b0;
        exp_q.delete();
        m_rows  = 0;
        m_alloc = 0;
        n_vec++;
        if (empty !== 1'b1 || num_rows !== '0 || commit_en !== '0 || full !== 1'b0 || dispatch_rob_addr !== '0) begin
            n_err++;
            $display("FAIL flush_state: got empty=%b num_rows=%0d commit_en=%b full=%b alloc=%0d, expected 1 0 00 0 0",
                     empty, num_rows, commit_en, full, dispatch_rob_addr);
        end
        step('0, '0, '0, 1, 2'b11, '0);
        idle(4);
        n_vec++;
        if (empty !== 1'b1 || commit_en !== '0) begin
            n_err++; $display("FAIL flush_ghost: got empty=%b commit_en=%b, expected 1 and 00", empty, commit_en);
        end
        rand_step(2'b10, 0, '0);
        complete_all();
        wait_drain(10);
    endtask

`ifdef ROB_EXCEPTION_EN
    task automatic test_exception();
        int row = m_alloc;
        rand_step(2'b11, 0, '0);
        exp_q[exp_q.size() - 1].en = 2'b01;
        step('0, '0, '0, row, 2'b11, 2'b10);
        @(posedge clk);
        #2;
        m_alloc = 0;
        n_vec++;
        if (commit_en !== 2'b01 || exception_valid !== 1'b1 || exception_bank_addr !== bank_t'(1) ||
            exception_rob_addr !== row_t'(row) || empty !== 1'b1 || num_rows !== '0) begin
            n_err++;
            $display("FAIL exception: got en=%b exc_valid=%b bank=%0d row=%0d empty=%b num_rows=%0d, expected 01 1 1 %0d 1 0",
                     commit_en, exception_valid, exception_bank_addr, exception_rob_addr, empty, num_rows, row);
        end
        idle(1);
        n_vec++;
        if (exception_valid !== 1'b0) begin n_err++; $display("FAIL exception_pulse: got %b, expected 0", exception_valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_order();
        test_full_wrap();
        test_flush();
`ifdef ROB_EXCEPTION_EN
        test_exception();
`endif
        idle(3);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL missing_commits: got %0d rows never retired, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
